// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types, constants and helpers for the SRAM port arbiter
package sram_arb_pkg;

    localparam int NUM_REQ  = 3;
    localparam int REQ_VGA  = 0;
    localparam int REQ_UART = 1;
    localparam int REQ_DEC  = 2;

    typedef enum logic [1:0] {
        S_ARB_IDLE,
        S_ARB_OWN,
        S_ARB_HANDOFF
    } arb_state_type;

    // Read-tracking tag carried down the latency delay line.
    typedef struct packed {
        logic       valid;
        logic [1:0] id;
    } arb_tag_t;

    // Isolate the lowest set bit: fixed priority, index 0 wins.
    function automatic logic [NUM_REQ-1:0] lowest_onehot(input logic [NUM_REQ-1:0] v);
        return v & (~v + 3'd1);
    endfunction

    function automatic logic [1:0] onehot_to_id(input logic [NUM_REQ-1:0] oh);
        logic [1:0] id;
        id = 2'd0;
        if (oh[REQ_UART]) id = 2'(REQ_UART);
        if (oh[REQ_DEC])  id = 2'(REQ_DEC);
        return id;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester-side and SRAM-side signal bundle of the arbiter
// master: the requester/board side (drives req, addr_n, we_n_n, wdata_n)
// slave:  the arbiter (drives grant, rd_valid and the SRAM_Controller port)
interface sram_arbiter_if;
    logic [2:0]  req;
    logic [17:0] addr_0;
    logic [17:0] addr_1;
    logic [17:0] addr_2;
    logic        we_n_0;
    logic        we_n_1;
    logic        we_n_2;
    logic [15:0] wdata_0;
    logic [15:0] wdata_1;
    logic [15:0] wdata_2;
    logic [2:0]  grant;
    logic [2:0]  rd_valid;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_write_data;

    modport master (
        output req, addr_0, addr_1, addr_2, we_n_0, we_n_1, we_n_2,
               wdata_0, wdata_1, wdata_2,
        input  grant, rd_valid, SRAM_address, SRAM_we_n, SRAM_write_data
    );

    modport slave (
        input  req, addr_0, addr_1, addr_2, we_n_0, we_n_1, we_n_2,
               wdata_0, wdata_1, wdata_2,
        output grant, rd_valid, SRAM_address, SRAM_we_n, SRAM_write_data
    );
endinterface

// File: rtl/sram_arb_tag_pipe.sv
// rtl/sram_arb_tag_pipe.sv - DEPTH-stage read tag delay line with asynchronous clear
// clk_i  : clock
// resetn : asynchronous active-low clear of every stage
// tag_i  : tag for the cycle being issued now
// tag_o  : tag issued DEPTH cycles ago
module sram_arb_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     resetn,
    input  arb_tag_t tag_i,
    output arb_tag_t tag_o
);

    arb_tag_t pipe_q [DEPTH];

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - fixed-priority, burst-limited arbiter for the shared SRAM_Controller port
// CLOCK_50_I : system clock
// resetn     : asynchronous active-low reset
// bus        : requests/addresses/write data in; grant, rd_valid and SRAM port out
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 1024
) (
    input  logic          CLOCK_50_I,
    input  logic          resetn,
    sram_arbiter_if.slave bus
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

    arb_state_type        state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]     burst_q, burst_d;
    // One-hot mask of the owner revoked by the burst limit, consulted in the handoff cycle.
    logic [NUM_REQ-1:0]   excl_q, excl_d;

    logic [NUM_REQ-1:0]   others_waiting;
    logic [NUM_REQ-1:0]   candidates;

    logic [17:0]          sram_address;
    logic                 sram_we_n;
    logic [15:0]          sram_write_data;
    arb_tag_t             tag_in;
    arb_tag_t             tag_out;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_ARB_IDLE;
            grant_q <= '0;
            burst_q <= '0;
            excl_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
            excl_q  <= excl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        burst_d = burst_q;
        excl_d  = excl_q;

        others_waiting = bus.req & ~grant_q;

        // The revoked owner only loses its turn if someone else actually wants the port.
        candidates = bus.req;
        if (|(bus.req & ~excl_q)) candidates = bus.req & ~excl_q;

        unique case (state_q)
            S_ARB_IDLE: begin
                if (|bus.req) begin
                    grant_d = lowest_onehot(bus.req);
                    burst_d = '0;
                    state_d = S_ARB_OWN;
                end
            end
            S_ARB_OWN: begin
                if (!(|(bus.req & grant_q))) begin
                    // A release wins over a coincident burst-limit hit: no exclusion.
                    grant_d = '0;
                    excl_d  = '0;
                    state_d = S_ARB_HANDOFF;
                end else if ((MAX_BURST != 0) && (burst_q == BURST_LAST) && (|others_waiting)) begin
                    grant_d = '0;
                    excl_d  = grant_q;
                    state_d = S_ARB_HANDOFF;
                end else if (|others_waiting) begin
                    if ((MAX_BURST != 0) && (burst_q != BURST_LAST)) burst_d = burst_q + 1'b1;
                end else begin
                    burst_d = '0;
                end
            end
            S_ARB_HANDOFF: begin
                excl_d = '0;
                if (|bus.req) begin
                    grant_d = lowest_onehot(candidates);
                    burst_d = '0;
                    state_d = S_ARB_OWN;
                end else begin
                    state_d = S_ARB_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                burst_d = '0;
                excl_d  = '0;
                state_d = S_ARB_IDLE;
            end
        endcase
    end

    // Port mux follows the registered grant; no owner parks the port as a read of address 0.
    always_comb begin
        sram_address    = 18'd0;
        sram_we_n       = 1'b1;
        sram_write_data = 16'd0;
        if (grant_q[REQ_VGA]) begin
            sram_address    = bus.addr_0;
            sram_we_n       = bus.we_n_0;
            sram_write_data = bus.wdata_0;
        end else if (grant_q[REQ_UART]) begin
            sram_address    = bus.addr_1;
            sram_we_n       = bus.we_n_1;
            sram_write_data = bus.wdata_1;
        end else if (grant_q[REQ_DEC]) begin
            sram_address    = bus.addr_2;
            sram_we_n       = bus.we_n_2;
            sram_write_data = bus.wdata_2;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = (|grant_q) & sram_we_n;
        tag_in.id    = onehot_to_id(grant_q);
    end

    sram_arb_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk_i  (CLOCK_50_I),
        .resetn (resetn),
        .tag_i  (tag_in),
        .tag_o  (tag_out)
    );

    assign bus.grant           = grant_q;
    assign bus.rd_valid        = tag_out.valid ? (3'b001 << tag_out.id) : 3'b000;
    assign bus.SRAM_address    = sram_address;
    assign bus.SRAM_we_n       = sram_we_n;
    assign bus.SRAM_write_data = sram_write_data;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the board's single SRAM_Controller port among three requesters: VGA display fetch, UART image upload and the image decoder (milestone units). It replaces the state-keyed address, write-enable and data muxes in the top level with a request/grant handshake. It grants the port using fixed priority with a burst limit and inserts a one-cycle dead cycle when ownership changes. It also tracks outstanding reads so that each requester receives a read-valid strobe aligned to its own data.

## Interface
Parameters:
- READ_LATENCY, 2: cycles from address issue to valid SRAM_read_data.
- MAX_BURST, 1024: maximum consecutive granted cycles while another requester waits. 0 means unlimited.

Ports:
- CLOCK_50_I  in  1  system clock, 50 MHz.
- resetn  in  1  reset, asynchronous, active-low.
- req  in  3  request per requester. Index 0 = VGA, 1 = UART, 2 = decoder.
- addr_0, addr_1, addr_2  in  18 each  requester address.
- we_n_0, we_n_1, we_n_2  in  1 each  requester write enable, active-low.
- wdata_0, wdata_1, wdata_2  in  16 each  requester write data.
- grant  out  3  one-hot grant, or all zero.
- rd_valid  out  3  per-requester strobe: SRAM_read_data is valid this cycle for that requester.
- SRAM_address  out  18  to SRAM_Controller.
- SRAM_we_n  out  1  to SRAM_Controller.
- SRAM_write_data  out  16  to SRAM_Controller.

## Operation
- FSM states, in package enum:
  - S_ARB_IDLE: no owner.
  - S_ARB_OWN: one owner holds the port.
  - S_ARB_HANDOFF: one dead cycle between owners.
- S_ARB_IDLE:
  - If any req bit is high, grant the lowest index among them and go to S_ARB_OWN. Load the burst counter with 0.
- S_ARB_OWN:
  - Owner drops req: clear grant and go to S_ARB_HANDOFF.
  - Burst limit: if MAX_BURST≠0, burst count reaches MAX_BURST−1, and any other req bit is high, revoke grant and go to S_ARB_HANDOFF.
  - Otherwise the burst counter increments while another requester waits and saturates at MAX_BURST−1. It resets to 0 when no other requester waits.
- S_ARB_HANDOFF:
  - Grant is zero for one cycle. SRAM_we_n = 1.
  - Next cycle, grant the lowest-index requester, excluding a requester that was revoked by the burst limit if another req bit is high. With no req bit high, go to S_ARB_IDLE.
- Port mux (combinational from the registered grant):
  - SRAM_address, SRAM_we_n and SRAM_write_data follow the granted requester.
  - With no grant: address 18'd0, we_n 1, wdata 16'd0.
- A requester treats a cycle as issued only when grant[i] is high in that cycle. A cycle in which req[i] is high but grant[i] is low is not issued.
- Read tracking: each cycle, push tag {valid = |grant & SRAM_we_n, id} into a READ_LATENCY-deep delay line. rd_valid[id] = 1 when the tag emerges with valid set.
- The delay line runs through handoffs and idle, so an owner change never drops or misroutes an outstanding read.

## Timing
- Reset values: grant = 0, rd_valid = 0, SRAM_address = 0, SRAM_we_n = 1, SRAM_write_data = 0. State = S_ARB_IDLE, burst counter = 0, delay line cleared.
- Grant latency: req rises in cycle t while idle → grant high in cycle t+1.
- Release: owner drops req in cycle t → grant low in t+1 (handoff) → next owner granted in t+2.
- Read: address issued in cycle t → rd_valid in cycle t+READ_LATENCY, coincident with SRAM_read_data.
- Simultaneous requests in idle: lowest index wins. Losers keep req high and get no grant until handoff.
- Owner drops req in the same cycle the burst limit hits: treat it as a normal release, so the owner is not excluded in handoff.
- resetn asserted mid-burst: everything returns to reset values immediately (asynchronous). In-flight rd_valid strobes are discarded.
- Writes never produce rd_valid.

## Structure
- sram_arb_pkg contains:
  - arb_state_type enum (S_ARB_IDLE, S_ARB_OWN, S_ARB_HANDOFF).
  - NUM_REQ = 3.
  - Requester index constants: REQ_VGA = 0, REQ_UART = 1, REQ_DEC = 2.
  - Tag struct {valid, id[1:0]}.
- Sub-module sram_arb_tag_pipe is the READ_LATENCY-deep tag shift register with asynchronous clear. The top level of the block contains the FSM, burst counter, priority select and output mux.

## Test plan
- Single requester: UART req with we_n = 0, addr = 5, wdata = 16'hABCD. Expected: grant = 3'b010 one cycle later; SRAM_we_n = 0, address = 5 and data = ABCD while granted; rd_valid stays 0.
- Read latency: decoder granted, reads addr 100..103 back-to-back. Expected: rd_valid[2] high for 4 consecutive cycles, starting 2 cycles after the first issue.
- Priority: req = 3'b110 from idle. Expected: grant = 010. Then UART drops req: one cycle with grant = 000 and SRAM_we_n = 1, then grant = 100.
- Burst limit: MAX_BURST = 4; decoder owns the port while VGA requests. Expected: decoder revoked after 4 cycles, handoff cycle, VGA granted. When VGA drops req, decoder is regranted.
- Read straddling handoff: UART issues a read in its last granted cycle, then the decoder is granted. Expected: rd_valid[1] (not [2]) fires 2 cycles later.
- Async reset mid-burst with reads outstanding. Expected: all outputs at reset values immediately, and no rd_valid after reset deassertion.
